// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / restoring divide engine for the EX stage.
// Produces a 2*WIDTH {hi,lo} result with a one-cycle done pulse in FIN.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               cancel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               div_by_zero_o,
  output logic               stallreq_o
);

  localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int DCW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t               state_reg, state_next;
  logic [2:0]           op_reg;
  logic [WIDTH-1:0]     opa_reg, opb_reg;
  logic [2*WIDTH-1:0]   hilo_reg;
  logic [MCW-1:0]       mul_cnt_reg;
  logic [DCW-1:0]       div_cnt_reg;
  logic [WIDTH-1:0]     rem_reg, quo_reg, dvs_reg;
  logic                 neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic                 done_reg, dbz_reg;

  logic                 accept, is_div_i, opa_neg, opb_neg, mul_last, div_last, qbit;
  logic [WIDTH-1:0]     opa_mag, opb_mag, rem_step, quo_step, q_fix, r_fix;
  logic [WIDTH:0]       shifted, diff;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, mul_res;

  assign accept   = start_i & ~cancel_i & (state_reg == IDLE);
  assign is_div_i = ~op_i[2] & op_i[1];
  assign opa_neg  = ~op_i[0] & opa_i[WIDTH-1];
  assign opb_neg  = ~op_i[0] & opb_i[WIDTH-1];
  assign opa_mag  = opa_neg ? -opa_i : opa_i;
  assign opb_mag  = opb_neg ? -opb_i : opb_i;
  assign mul_last = (mul_cnt_reg == MCW'(MUL_LATENCY - 1));
  assign div_last = (div_cnt_reg == '0);

  // op_reg[0] selects unsigned operands; op_reg[2] selects accumulate, op_reg[1] subtract.
  assign ext_a   = op_reg[0] ? {{WIDTH{1'b0}}, opa_reg} : {{WIDTH{opa_reg[WIDTH-1]}}, opa_reg};
  assign ext_b   = op_reg[0] ? {{WIDTH{1'b0}}, opb_reg} : {{WIDTH{opb_reg[WIDTH-1]}}, opb_reg};
  assign prod    = ext_a * ext_b;
  assign mul_res = op_reg[2] ? (op_reg[1] ? hilo_reg - prod : hilo_reg + prod) : prod;

  // One restoring step: quo_reg shifts the dividend out as quotient bits shift in.
  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_reg};
  assign qbit     = ~diff[WIDTH];
  assign rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], qbit};
  assign q_fix    = neg_q_reg ? -quo_step : quo_step;
  assign r_fix    = neg_r_reg ? -rem_step : rem_step;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (!is_div_i)          state_next = MUL;
        else if (opb_i == '0)   state_next = FIN;
        else                    state_next = DIV;
      end
      MUL:  if (cancel_i)       state_next = IDLE;
            else if (mul_last)  state_next = FIN;
      DIV:  if (cancel_i)       state_next = IDLE;
            else if (div_last)  state_next = FIN;
      FIN:                      state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      hilo_reg    <= '0;
      mul_cnt_reg <= '0;
      div_cnt_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        IDLE: if (accept) begin
          op_reg      <= op_i;
          opa_reg     <= opa_i;
          opb_reg     <= opb_i;
          hilo_reg    <= hilo_i;
          mul_cnt_reg <= '0;
          div_cnt_reg <= DCW'(WIDTH - 1);
          rem_reg     <= '0;
          quo_reg     <= opa_mag;
          dvs_reg     <= opb_mag;
          neg_q_reg   <= opa_neg ^ opb_neg;
          neg_r_reg   <= opa_neg;
          if (is_div_i && opb_i == '0) begin
            hi_reg   <= opa_i;
            lo_reg   <= '1;
            done_reg <= 1'b1;
            dbz_reg  <= 1'b1;
          end
        end
        MUL: if (!cancel_i) begin
          mul_cnt_reg <= mul_cnt_reg + 1'b1;
          if (mul_last) begin
            {hi_reg, lo_reg} <= mul_res;
            done_reg         <= 1'b1;
          end
        end
        DIV: if (!cancel_i) begin
          rem_reg     <= rem_step;
          quo_reg     <= quo_step;
          div_cnt_reg <= div_cnt_reg - 1'b1;
          if (div_last) begin
            hi_reg   <= r_fix;
            lo_reg   <= q_fix;
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_reg == MUL) || (state_reg == DIV);
  assign done_o        = done_reg;
  assign div_by_zero_o = dbz_reg;
  assign hi_o          = hi_reg;
  assign lo_o          = lo_reg;
  assign stallreq_o    = ~rst & (busy_o | (start_i & (state_reg == IDLE) & ~cancel_i));

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic model plus per-cycle compare on a 32-bit instance,
// directed literal checks on both the 32-bit and a 16-bit/latency-1 instance.
module tb_muldiv_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] opa, opb, hi, lo;
  logic [63:0] hilo;
  logic        busy, done, dbz, stall;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;
  logic [31:0] hilo16;
  logic        busy16, done16, dbz16, stall16;

  muldiv_unit #(.WIDTH(32), .MUL_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
    .hilo_i(hilo), .cancel_i(cancel), .busy_o(busy), .done_o(done), .hi_o(hi),
    .lo_o(lo), .div_by_zero_o(dbz), .stallreq_o(stall));

  muldiv_unit #(.WIDTH(16), .MUL_LATENCY(1)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .op_i(op16), .opa_i(a16), .opb_i(b16),
    .hilo_i(hilo16), .cancel_i(1'b0), .busy_o(busy16), .done_o(done16), .hi_o(hi16),
    .lo_o(lo16), .div_by_zero_o(dbz16), .stallreq_o(stall16));

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Result of an op straight from the ISA definition, plus its done latency.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h, output logic [63:0] res, output logic z,
                       output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    if (o == 3'b010 || o == 3'b011) begin
      if (b == 32'd0) begin
        res = {a, 32'hFFFF_FFFF}; z = 1'b1; lat = 1;
      end else begin
        lat = 33;
        if (o == 3'b010) begin
          q = sa / sb; r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    end else begin
      lat = 3;
      if (o[0]) p = {32'd0, a} * {32'd0, b};
      else      p = sa * sb;
      res = o[2] ? (o[1] ? h - p : h + p) : p;
    end
  endtask

  int          m_sb = 1, m_se = 0, m_done = -1;
  logic [63:0] m_res = '0, last_res = '0;
  logic        m_z = 1'b0;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done_o", done, cyc == m_done);
      chk("stallreq_o", stall, (cyc >= m_sb) && (cyc <= m_se));
      chk("busy_o", busy, (cyc > m_sb) && (cyc <= m_se));
      if (cyc == m_done) begin
        chk("result", {hi, lo}, m_res);
        chk("div_by_zero_o", dbz, m_z);
        last_res = m_res;
      end else begin
        chk("result_hold", {hi, lo}, last_res);
        chk("div_by_zero_o_idle", dbz, 1'b0);
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 of the IDLE cycle after FIN.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] h, output int seen_lat);
    int lat; logic [63:0] r; logic z;
    model(o, a, b, h, r, z, lat);
    start = 1'b1; op = o; opa = a; opb = b; hilo = h;
    m_res = r; m_z = z; m_sb = cyc; m_se = cyc + lat - 1; m_done = cyc + lat;
    @(posedge clk); #2;
    op = 3'($urandom); opa = $urandom; opb = $urandom; hilo = {$urandom, $urandom};
    seen_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if (done) begin seen_lat = k; break; end
    end
    if (seen_lat < 0) chk({name, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #2;
    start = 1'b0;
    $display("op %s: op=%b a=%h b=%h hilo=%h -> hi=%h lo=%h latency=%0d",
             name, o, a, b, h, hi, lo, seen_lat);
  endtask

  task automatic run16(input string name, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, output int seen_lat);
    start16 = 1'b1; op16 = o; a16 = a; b16 = b; hilo16 = '0;
    @(posedge clk); #2;
    a16 = 16'($urandom); b16 = 16'($urandom);
    seen_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if (done16) begin seen_lat = k; break; end
    end
    if (seen_lat < 0) chk({name, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #2;
    start16 = 1'b0;
    $display("op16 %s: op=%b a=%h b=%h -> hi=%h lo=%h latency=%0d", name, o, a, b, hi16, lo16, seen_lat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int l;
    int acc;
    logic [63:0] r; logic z;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; opa = '0; opb = '0; hilo = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; hilo16 = '0;
    @(posedge clk); @(negedge clk);
    chk("reset_result", {hi, lo}, 64'd0);
    chk("reset_flags", {busy, done, dbz, stall}, 4'd0);
    chk("reset_result16", {hi16, lo16, busy16, done16, dbz16, stall16}, 36'd0);
    @(posedge clk); #2;
    rst = 1'b0; chk_en = 1'b1;

    do_op("MULT", 3'b000, 32'hFFFF_FFFD, 32'd5, 64'd0, l);
    chk("mult_lat", l, 3);
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("MULTU_b2b", 3'b001, 32'hFFFF_FFFF, 32'd2, 64'd0, l);
    chk("multu_res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    idle(2);
    do_op("DIV", 3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0, l);
    chk("div_lat", l, 33);
    chk("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("DIVU", 3'b011, 32'd7, 32'd2, 64'd0, l);
    chk("divu_res", {hi, lo}, 64'h0000_0001_0000_0003);
    do_op("MSUB", 3'b110, 32'd3, 32'd7, 64'h10, l);
    chk("msub_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
    do_op("MADDU", 3'b101, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, l);
    chk("maddu_wrap", {hi, lo}, 64'd0);
    do_op("DIVU0", 3'b011, 32'h1234, 32'd0, 64'd0, l);
    chk("dbz_lat", l, 1);
    chk("dbz_res", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    do_op("DIVMIN", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, l);
    chk("divmin_res", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op("MADD", 3'b100, 32'hFFFF_FFFE, 32'd3, 64'h100, l);
    chk("madd_res", {hi, lo}, 64'h0000_0000_0000_00FA);
    do_op("DIVnn", 3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'd0, l);
    chk("div_nn", {hi, lo}, 64'hFFFF_FFFF_0000_0003);
    do_op("DIVpn", 3'b010, 32'd7, 32'hFFFF_FFFE, 64'd0, l);
    chk("div_pn", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    do_op("DIVUbig", 3'b011, 32'hFFFF_FFFF, 32'h10, 64'd0, l);
    chk("divu_big", {hi, lo}, 64'h0000_000F_0FFF_FFFF);
    do_op("MSUBU", 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, l);
    chk("msubu_res", {hi, lo}, 64'h0000_0001_FFFF_FFFF);

    // cancel held with start in IDLE: nothing may be accepted
    start = 1'b1; cancel = 1'b1; op = 3'b000; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #2;
    start = 1'b0; cancel = 1'b0;
    idle(3);
    $display("cancel in IDLE: busy=%b result=%h", busy, {hi, lo});

    // cancel in cycle 10 of a DIV
    model(3'b010, 32'd100, 32'd3, 64'd0, r, z, l);
    start = 1'b1; op = 3'b010; opa = 32'd100; opb = 32'd3;
    acc = cyc; m_res = r; m_z = z; m_sb = acc; m_se = acc + l - 1; m_done = acc + l;
    repeat (10) @(posedge clk);
    #2;
    cancel = 1'b1; start = 1'b0; m_done = -1; m_se = acc + 10;
    @(posedge clk); #2;
    cancel = 1'b0;
    idle(4);
    chk("cancel_hold", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
    $display("cancel mid-DIV: busy=%b result=%h", busy, {hi, lo});

    // reset while in MUL
    start = 1'b1; op = 3'b000; opa = 32'd5; opb = 32'd5;
    m_sb = cyc; m_se = cyc + 2; m_done = cyc + 3; m_res = 64'd25; m_z = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b0; rst = 1'b1; start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_result", {hi, lo}, 64'd0);
    chk("rst_mid_flags", {busy, done, dbz, stall}, 4'd0);
    @(posedge clk); #2;
    rst = 1'b0; last_res = '0; m_done = -1; m_sb = 1; m_se = 0; chk_en = 1'b1;
    idle(4);
    $display("reset mid-MUL: result=%h busy=%b", {hi, lo}, busy);
    do_op("MULT_after_rst", 3'b000, 32'd6, 32'hFFFF_FFF9, 64'd0, l);
    chk("mult_after_rst", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    run16("MULTU16", 3'b001, 16'hFFFF, 16'hFFFF, l);
    chk("multu16_lat", l, 2);
    chk("multu16_res", {hi16, lo16}, 32'hFFFE_0001);
    run16("DIV16", 3'b010, 16'hFF9C, 16'd7, l);
    chk("div16_lat", l, 17);
    chk("div16_res", {hi16, lo16}, 32'hFFFE_FFF2);
    run16("DIVU16_0", 3'b011, 16'hABCD, 16'd0, l);
    chk("dbz16_lat", l, 1);
    chk("dbz16_res", {hi16, lo16}, 32'hABCD_FFFF);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
